parity_frame_rx: RTL
====================

# parity_frame_rx

Serial frame receiver that checks parity for the XOR parity generator's output stream. It deserializes start/data/parity/stop frames from a single-bit line and presents the data word together with parity and framing status. The block sits at the receiving end of the link, downstream of the line driver. It is advanced by an external one-cycle bit strobe, so it contains no baud generation.

## Interface
- `DATA_W`, default 8: data bits per frame, 2..16.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `bit_en` input 1: bit strobe; the line is sampled only on cycles where it is 1.
- `rxd` input 1: serial line; idles high.
- `odd` input 1: parity sense. 0 selects even parity, 1 selects odd; this matches the generator's injected `v` bit.
- `data` output DATA_W: last received word, LSB first on the line.
- `valid` output 1: one-cycle pulse when a frame completes with a good stop bit.
- `parity_err` output 1: parity status of the word on `data`; valid while `data` is held.
- `frame_err` output 1: one-cycle pulse on a bad stop bit.
- `err_cnt` output 8: saturating parity-error count. Present only with `PARITY_FRAME_RX_ERRCNT_EN`.

## Operation
- Frame format, one bit per `bit_en`: start bit (0), DATA_W data bits LSB first, parity bit P, stop bit (1).
- FSM states and transitions, taken only on cycles with `bit_en`=1:
  - IDLE: `rxd`=0 → DATA. On entry to DATA, clear the bit counter and latch `odd` into `odd_q`. `rxd`=1 → stay in IDLE.
  - DATA: shift `rxd` into the shift register at bit position counter. After the DATA_W-th bit → PAR.
  - PAR: latch P → STOP.
  - STOP, `rxd`=1: load `data` from the shift register and set `parity_err` = ^shift ^ P ^ `odd_q`. Pulse `valid` → IDLE.
  - STOP, `rxd`=0: pulse `frame_err`. Leave `data` and `parity_err` unchanged. No `valid` → BREAK.
  - BREAK: `rxd`=1 → IDLE. `rxd`=0 → stay in BREAK. A held-low line never starts a phantom frame.
- Cycles with `bit_en`=0 hold all state. `valid` and `frame_err` are 0 on those cycles.
- A change on `odd` mid-frame has no effect; only the value latched at the start bit is used.
- Parity rule: the XOR of the DATA_W data bits and P must equal `odd_q`. Otherwise `parity_err`=1.
- A frame with a parity error still asserts `valid`. The consumer decides whether to discard it.
- The bit counter is ceil(log2(DATA_W+1)) bits wide. It never wraps within a frame.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `err_cnt`=0. FSM is in IDLE.
- Reset is asynchronous and takes effect immediately, including mid-frame. The partial frame is discarded and produces no pulse.
- `valid` and `frame_err` assert in the cycle after the `bit_en` cycle that samples the stop bit. Both are registered, and each lasts exactly 1 clk.
- `data` and `parity_err` update in the same cycle as `valid` and hold until the next good frame.
- Back-to-back frames are supported. A start bit sampled on the `bit_en` right after a stop bit begins a new frame with no idle bit required.
- Latency from the start-bit strobe to `valid` is DATA_W+3 strobes, plus 1 clk.

## Configuration
- `PARITY_FRAME_RX_ERRCNT_EN` defined:
  - `err_cnt` port exists.
  - It increments by 1 on each `valid` pulse that carries `parity_err`=1.
  - It saturates at 255, and only `reset_n` clears it.
  - Framing errors are not counted.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-frame: drop `reset_n` after 3 data bits → all outputs 0 at once. Then send 0x3C, even parity, P=0 → `valid`=1, `data`=0x3C, `parity_err`=0.
- Parity sense: send 0xA5 with `odd`=1, P=1 → `parity_err`=0. Send 0xA5 with `odd`=1, P=0 → `parity_err`=1, `valid`=1. With ERRCNT_EN, `err_cnt` goes to 1.
- Framing: send 0x55 with a 0 stop bit, then hold `rxd` low for 5 strobes → one `frame_err` pulse, no `valid`, `data` unchanged. No new frame starts until `rxd` has been high for 1 strobe.
- Strobe gaps: send 0x81 with random 0–7 idle clks between `bit_en` pulses → `valid` exactly once, `data`=0x81.
- Back-to-back: send frames 0x01, 0xFE, 0x7F, even parity, with no idle bits between them → three `valid` pulses in order, each with `parity_err`=0.
- Saturation (ERRCNT_EN): send 260 frames with bad parity → `err_cnt`=255 and it holds; `valid` pulses 260 times.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// parity_frame_rx_if: strobe/line/parity-sense inputs and received-word outputs of parity_frame_rx.
// With PARITY_FRAME_RX_ERRCNT_EN defined the saturating parity-error count is carried as well.
interface parity_frame_rx_if #(parameter int DATA_W = 8);
    logic              bit_en;
    logic              rxd;
    logic              odd;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    logic [7:0]        err_cnt;
    modport master (output bit_en, rxd, odd, input data, valid, parity_err, frame_err, err_cnt);
    modport slave  (input bit_en, rxd, odd, output data, valid, parity_err, frame_err, err_cnt);
`else
    modport master (output bit_en, rxd, odd, input data, valid, parity_err, frame_err);
    modport slave  (input bit_en, rxd, odd, output data, valid, parity_err, frame_err);
`endif
endinterface

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: strobe-driven start/data/parity/stop deserializer with parity and framing status.
// Optional feature macro: PARITY_FRAME_RX_ERRCNT_EN adds a saturating parity-error counter.
module parity_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    parity_frame_rx_if.slave s
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, BRK} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              odd_q, odd_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    // State register: every flop, cleared immediately by reset so a partial frame is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            odd_q   <= 1'b0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            odd_q   <= odd_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    // Next state: advance one frame position per strobe; a low line after a bad stop parks in BRK
    always_comb begin
        state_d = state_q;
        if (s.bit_en) begin
            case (state_q)
                IDLE:    state_d = s.rxd ? IDLE : DATA;
                DATA:    state_d = (cnt_q == LAST) ? PAR : DATA;
                PAR:     state_d = STOP;
                STOP:    state_d = s.rxd ? IDLE : BRK;
                default: state_d = s.rxd ? IDLE : BRK;
            endcase
        end
    end

    // Datapath and outputs: shift data in LSB first, publish word and parity on a good stop bit
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        odd_d   = odd_q;
        par_d   = par_q;
        perr_d  = perr_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (s.bit_en) begin
            if (state_q == IDLE && !s.rxd) begin
                cnt_d = '0;
                odd_d = s.odd;
            end
            if (state_q == DATA) begin
                shift_d = {s.rxd, shift_q[DATA_W-1:1]};
                cnt_d   = cnt_q + CW'(1);
            end
            if (state_q == PAR) par_d = s.rxd;
            if (state_q == STOP) begin
                valid_d = s.rxd;
                ferr_d  = !s.rxd;
                if (s.rxd) begin
                    data_d = shift_q;
                    perr_d = ^shift_q ^ par_q ^ odd_q;
                end
            end
        end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        err_cnt_d = (valid_d && perr_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
    end

    assign s.data       = data_q;
    assign s.valid      = valid_q;
    assign s.parity_err = perr_q;
    assign s.frame_err  = ferr_q;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    assign s.err_cnt    = err_cnt_q;
`endif
endmodule
